mem_arbiter: RTL and testbench

Two-port arbiter sharing the single block-wide main memory between the instruction cache (read-only) and the data cache (read/write). It sits between the caches' memory-side ports (`mem_read`/`mem_write`/`mem_address`/`mem_busywait` style handshakes) and one memory instance. It serialises block transfers, grants round-robin on contention, and returns read blocks to the winning cache with a one-cycle completion pulse on that cache's busywait.

---
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one block-wide memory between the icache (read-only)
// and the dcache (read/write); serialises block transfers and returns read blocks.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned BLOCK_W = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_read,
  input  logic [ADDR_W-1:0]  i_address,
  output logic [BLOCK_W-1:0] i_readdata,
  output logic               i_busywait,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [ADDR_W-1:0]  d_address,
  input  logic [BLOCK_W-1:0] d_writedata,
  output logic [BLOCK_W-1:0] d_readdata,
  output logic               d_busywait,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [BLOCK_W-1:0] mem_writedata,
  input  logic [BLOCK_W-1:0] mem_readdata,
  input  logic               mem_busywait
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic               r_first;
  logic               r_grant;
  logic               r_last_grant;
  logic [BLOCK_W-1:0] r_i_readdata;
  logic [BLOCK_W-1:0] r_d_readdata;
  logic               r_mem_read;
  logic               r_mem_write;
  logic [ADDR_W-1:0]  r_mem_address;
  logic [BLOCK_W-1:0] r_mem_writedata;

  logic w_i_req;
  logic w_d_req;
  logic w_pick_d;
  logic w_start;
  logic w_done;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

  // On a tie the port that did not win last time is served.
  assign w_pick_d = w_d_req & (~w_i_req | (r_last_grant == GRANT_I));
  assign w_start  = (r_state == S_IDLE) & (w_i_req | w_d_req);
  // The memory's busywait is not yet valid in the first BUSY cycle.
  assign w_done   = (r_state == S_BUSY) & ~r_first & ~mem_busywait;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_start) w_next_state = S_BUSY;
      S_BUSY:    if (w_done)  w_next_state = S_RELEASE;
      S_RELEASE: w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_first         <= 1'b0;
      r_grant         <= GRANT_I;
      r_last_grant    <= GRANT_D;
      r_i_readdata    <= '0;
      r_d_readdata    <= '0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_address   <= '0;
      r_mem_writedata <= '0;
    end else begin
      r_state <= w_next_state;
      r_first <= w_start;
      if (w_start) begin
        r_grant       <= w_pick_d;
        r_mem_address <= w_pick_d ? d_address : i_address;
        // A simultaneous dcache read+write is treated as a write-back.
        r_mem_write   <= w_pick_d & d_write;
        r_mem_read    <= ~w_pick_d | ~d_write;
        if (w_pick_d) r_mem_writedata <= d_writedata;
      end
      if (w_done) begin
        r_mem_read   <= 1'b0;
        r_mem_write  <= 1'b0;
        r_last_grant <= r_grant;
        if (r_mem_read) begin
          if (r_grant == GRANT_D) r_d_readdata <= mem_readdata;
          else                    r_i_readdata <= mem_readdata;
        end
      end
    end
  end

  assign i_busywait    = w_i_req & ~((r_state == S_RELEASE) & (r_grant == GRANT_I));
  assign d_busywait    = w_d_req & ~((r_state == S_RELEASE) & (r_grant == GRANT_D));
  assign i_readdata    = r_i_readdata;
  assign d_readdata    = r_d_readdata;
  assign mem_read      = r_mem_read;
  assign mem_write     = r_mem_write;
  assign mem_address   = r_mem_address;
  assign mem_writedata = r_mem_writedata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a behavioural memory with programmable busy time,
// directed request sequences, and a monitor that checks every completion pulse.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned BLOCK_W = 128;

  localparam logic [BLOCK_W-1:0] D_A5   = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_69A5;
  localparam logic [BLOCK_W-1:0] D_10   = 128'h1010_1010_1010_1010_1010_1010_1010_1010;
  localparam logic [BLOCK_W-1:0] D_22   = 128'h2222_2222_2222_2222_2222_2222_2222_2222;
  localparam logic [BLOCK_W-1:0] D_DEAD = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
  localparam logic [BLOCK_W-1:0] D_BEEF = 128'hBEEF_0008_CAFE_F00D_1234_5678_9ABC_DEF0;

  logic               clk = 1'b0;
  logic               reset;
  logic               i_read, d_read, d_write;
  logic [ADDR_W-1:0]  i_address, d_address;
  logic [BLOCK_W-1:0] d_writedata;
  logic [BLOCK_W-1:0] i_readdata, d_readdata;
  logic               i_busywait, d_busywait;
  logic               mem_read, mem_write;
  logic [ADDR_W-1:0]  mem_address;
  logic [BLOCK_W-1:0] mem_writedata;
  logic [BLOCK_W-1:0] mem_readdata;
  logic               mem_busywait;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_busywait(d_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  always #5 clk = ~clk;

  // Behavioural memory: busy for 'lat' cycles after a request first appears.
  logic [BLOCK_W-1:0] mem [0:63];
  int unsigned lat = 1;
  int unsigned cnt = 0;
  assign mem_busywait = (mem_read | mem_write) && (cnt < lat);
  assign mem_readdata = mem[mem_address];
  always @(posedge clk) begin
    if (mem_read | mem_write) cnt <= cnt + 1;
    else                      cnt <= 0;
    if (mem_write && !mem_busywait) mem[mem_address] <= mem_writedata;
  end

  task automatic chk(input string name, input logic [BLOCK_W-1:0] act, input logic [BLOCK_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic               port;
    logic               wr;
    logic [ADDR_W-1:0]  addr;
    logic [BLOCK_W-1:0] data;
  } exp_t;
  exp_t sbq[$];

  task automatic push(input logic port, input logic wr, input logic [ADDR_W-1:0] a, input logic [BLOCK_W-1:0] dt);
    exp_t e;
    e.port = port; e.wr = wr; e.addr = a; e.data = dt;
    sbq.push_back(e);
  endtask

  // Monitor: captures the memory request and checks each completion against the queue.
  logic               mon_en = 1'b0;
  logic               cap_rd = 1'b0, cap_wr = 1'b0;
  logic [ADDR_W-1:0]  cap_addr = '0;
  logic [BLOCK_W-1:0] cap_wd = '0;
  logic [BLOCK_W-1:0] exp_i_rd = '0, exp_d_rd = '0;

  task automatic complete(input logic port, input logic [BLOCK_W-1:0] rdata);
    exp_t e;
    if (sbq.size() == 0) begin
      chk("unexpected_completion", 128'(port), 128'(2));
    end else begin
      e = sbq.pop_front();
      chk("sb_port", 128'(port), 128'(e.port));
      chk("sb_mem_write", 128'(cap_wr), 128'(e.wr));
      chk("sb_mem_read", 128'(cap_rd), 128'(!e.wr));
      chk("sb_mem_address", 128'(cap_addr), 128'(e.addr));
      if (e.wr) chk("sb_mem_writedata", cap_wd, e.data);
      else begin
        chk("sb_readdata", rdata, e.data);
        if (port) exp_d_rd = e.data;
        else      exp_i_rd = e.data;
      end
    end
    cap_rd = 1'b0; cap_wr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_read | mem_write) begin
        cap_rd = mem_read; cap_wr = mem_write; cap_addr = mem_address; cap_wd = mem_writedata;
      end
      if (i_read && !i_busywait)              complete(1'b0, i_readdata);
      if ((d_read | d_write) && !d_busywait)  complete(1'b1, d_readdata);
      chk("i_readdata_hold", i_readdata, exp_i_rd);
      chk("d_readdata_hold", d_readdata, exp_d_rd);
      if (!i_read)             chk("i_busywait_norq", 128'(i_busywait), 128'(0));
      if (!(d_read | d_write)) chk("d_busywait_norq", 128'(d_busywait), 128'(0));
      if (reset) begin
        exp_i_rd = '0; exp_d_rd = '0;
      end
    end
  end

  // One transaction on one port; optionally moves d_address mid-transfer.
  task automatic txn(input logic port, input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                     input logic [ADDR_W-1:0] alt_a, input int alt_at, input logic [BLOCK_W-1:0] wd,
                     input logic [BLOCK_W-1:0] expd, input int unsigned l);
    logic done;
    bit   ok = 1'b0;
    lat = l;
    push(port, port & wr, a, (port & wr) ? wd : expd);
    if (port) begin
      d_address = a; d_read = rd; d_write = wr; d_writedata = wd;
    end else begin
      i_address = a; i_read = 1'b1;
    end
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      done = port ? ((d_read | d_write) && !d_busywait) : (i_read && !i_busywait);
      @(posedge clk); #1;
      if (n + 1 == alt_at) d_address = alt_a;
      if (done) begin
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("txn_timeout", 128'(0), 128'(1));
  endtask

  // Both caches read at once; each request drops after its own completion pulse.
  task automatic tie(input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da,
                     input logic [BLOCK_W-1:0] ie, input logic [BLOCK_W-1:0] de, input logic d_first);
    logic di, dd;
    lat = 2;
    if (d_first) begin push(1'b1, 1'b0, da, de); push(1'b0, 1'b0, ia, ie); end
    else         begin push(1'b0, 1'b0, ia, ie); push(1'b1, 1'b0, da, de); end
    i_address = ia; d_address = da; i_read = 1'b1; d_read = 1'b1;
    for (int n = 0; n < 200 && (i_read || d_read); n++) begin
      @(negedge clk);
      di = i_read && !i_busywait;
      dd = d_read && !d_busywait;
      @(posedge clk); #1;
      if (di) i_read = 1'b0;
      if (dd) d_read = 1'b0;
    end
    if (i_read || d_read) begin
      chk("tie_timeout", 128'(0), 128'(1));
      i_read = 1'b0; d_read = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[6'h05] = D_A5;
    mem[6'h10] = D_10;
    mem[6'h22] = D_22;
    reset = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; d_writedata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_i_readdata", i_readdata, '0);
    chk("rst_d_readdata", d_readdata, '0);
    chk("rst_mem_read", 128'(mem_read), 128'(0));
    chk("rst_mem_write", 128'(mem_write), 128'(0));
    chk("rst_mem_address", 128'(mem_address), 128'(0));
    chk("rst_mem_writedata", mem_writedata, '0);
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Icache read, memory busy 4 cycles: request cycles 1..5, pulse in cycle 6.
    lat = 4;
    push(1'b0, 1'b0, 6'h05, D_A5);
    i_address = 6'h05; i_read = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("t1_mem_read_c%0d", c), 128'(mem_read), 128'(c <= 5));
      if (c <= 5) chk($sformatf("t1_mem_addr_c%0d", c), 128'(mem_address), 128'(6'h05));
      chk($sformatf("t1_i_busywait_c%0d", c), 128'(i_busywait), 128'(c != 6));
      chk($sformatf("t1_d_busywait_c%0d", c), 128'(d_busywait), 128'(0));
    end
    @(posedge clk); #1;
    i_read = 1'b0;
    @(negedge clk);
    chk("t1_idle_mem_read", 128'(mem_read), 128'(0));
    @(posedge clk); #1;

    txn(1'b1, 1'b0, 1'b1, 6'h3F, 6'h00, 0, D_DEAD, '0, 2);     // dcache write-back
    txn(1'b1, 1'b1, 1'b0, 6'h3F, 6'h00, 0, '0, D_DEAD, 1);     // read it back
    tie(6'h05, 6'h10, D_A5, D_10, 1'b0);                       // I then D
    tie(6'h22, 6'h05, D_22, D_A5, 1'b0);                       // I then D again
    txn(1'b0, 1'b1, 1'b0, 6'h10, 6'h00, 0, '0, D_10, 0);       // icache alone
    tie(6'h05, 6'h22, D_A5, D_22, 1'b1);                       // last was I: D wins
    txn(1'b1, 1'b1, 1'b1, 6'h08, 6'h00, 0, D_BEEF, '0, 3);     // read+write -> write
    txn(1'b0, 1'b1, 1'b0, 6'h08, 6'h00, 0, '0, D_BEEF, 2);
    txn(1'b1, 1'b1, 1'b0, 6'h10, 6'h22, 2, '0, D_10, 5);       // address moves mid-BUSY

    // Reset during the third BUSY cycle aborts the transfer.
    lat = 8;
    i_address = 6'h22; i_read = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; i_read = 1'b0;
    @(negedge clk);
    chk("rst_mid_mem_read_before", 128'(mem_read), 128'(1));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_mem_read", 128'(mem_read), 128'(0));
    chk("rst_mid_mem_address", 128'(mem_address), 128'(0));
    chk("rst_mid_i_readdata", i_readdata, '0);
    chk("rst_mid_d_readdata", d_readdata, '0);
    @(posedge clk); #1;
    tie(6'h10, 6'h05, D_10, D_A5, 1'b0);                       // last_grant back to D: I wins

    repeat (3) @(posedge clk);
    chk("sb_empty", 128'(sbq.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
